// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC read/write control logic.
package pic_pkg;

  // Initialization sequence states
  typedef enum logic [1:0] {
    READY     = 2'd0,
    WAIT_ICW2 = 2'd1,
    WAIT_ICW3 = 2'd2,
    WAIT_ICW4 = 2'd3
  } init_state_t;

  // Read source encodings handed to the data bus buffer
  localparam logic [1:0] SEL_IRR = 2'b00;
  localparam logic [1:0] SEL_ISR = 2'b01;
  localparam logic [1:0] SEL_IMR = 2'b10;

  // Register reset values; OCW3 comes up selecting IRR reads
  localparam logic [7:0] OCW3_RST = 8'h02;
  localparam logic [7:0] REG_RST  = 8'h00;

endpackage

// File: rtl/pic_strobe_sync.sv
// Per-bit strobe sampler. RW_SYNC_EN defined: 2-flop synchronizer for
// asynchronous CPU pins. Undefined: one register stage for pins already
// synchronous to clk. Inputs are expected active-high (idle = 0).
module pic_strobe_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

`ifdef RW_SYNC_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic [WIDTH-1:0] stage_reg [DEPTH];

  // First stage samples the raw pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_reg[0] <= '0;
    else        stage_reg[0] <= din;
  end

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_stage
      // Additional metastability-settling stages
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_reg[gi] <= '0;
        else        stage_reg[gi] <= stage_reg[gi-1];
      end
    end
  endgenerate

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/pic_read_write_logic.sv
// 8259A-style read/write control: samples CPU strobes, produces RD/WR
// flags, captures written bytes and runs the ICW1-ICW4 init sequence.
// Strobe sampling depth is set by the RW_SYNC_EN macro in pic_strobe_sync.
module pic_read_write_logic
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] ds_in,
  output logic       rd_flag,
  output logic       wr_flag,
  output logic [1:0] read_sel,
  output logic [7:0] icw1,
  output logic [7:0] icw2,
  output logic [7:0] icw3,
  output logic [7:0] icw4,
  output logic [7:0] imr,
  output logic [7:0] ocw2,
  output logic [7:0] ocw3,
  output logic       icw1_stb,
  output logic       ocw2_stb,
  output logic       ocw3_stb,
  output logic       init_done
);

  logic [3:0]  samp;
  logic        s_cs, s_rd, s_wr, s_a0;
  logic        wr_flag_q;
  logic [7:0]  data_reg;
  logic        a0_reg;
  logic        commit, is_icw1;
  logic        ld_icw2, ld_icw3, ld_icw4, ld_imr, ld_ocw2, ld_ocw3;
  init_state_t state_reg, state_next;

  // Strobes are inverted to active-high so the sampler resets to "idle"
  pic_strobe_sync #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({~cs_n, ~rd_n, ~wr_n, a0}),
    .dout  (samp)
  );

  assign s_cs = samp[3];
  assign s_rd = samp[2];
  assign s_wr = samp[1];
  assign s_a0 = samp[0];

  // Overlapping RD/WR blocks both flags
  assign rd_flag  = s_cs & s_rd & ~s_wr;
  assign wr_flag  = s_cs & s_wr & ~s_rd;
  assign read_sel = s_a0 ? SEL_IMR : (ocw3[0] ? SEL_ISR : SEL_IRR);

  // A commit needs WR# to be the strobe that ended the cycle while CS# held
  assign commit  = wr_flag_q & ~s_wr & s_cs;
  assign is_icw1 = commit & ~a0_reg & data_reg[4];

  // Capture the write byte/address every cycle the write flag is active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_flag_q <= 1'b0;
      data_reg  <= REG_RST;
      a0_reg    <= 1'b0;
    end else begin
      wr_flag_q <= wr_flag;
      if (wr_flag) begin
        data_reg <= ds_in;
        a0_reg   <= s_a0;
      end
    end
  end

  // Init FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= READY;
    else        state_reg <= state_next;
  end

  // Next-state and register-load decode for a committed write
  always_comb begin
    state_next = state_reg;
    ld_icw2    = 1'b0;
    ld_icw3    = 1'b0;
    ld_icw4    = 1'b0;
    ld_imr     = 1'b0;
    ld_ocw2    = 1'b0;
    ld_ocw3    = 1'b0;
    if (is_icw1) begin
      state_next = WAIT_ICW2;
    end else if (commit) begin
      unique case (state_reg)
        WAIT_ICW2: if (a0_reg) begin
          ld_icw2 = 1'b1;
          if (!icw1[1])    state_next = WAIT_ICW3;
          else if (icw1[0]) state_next = WAIT_ICW4;
          else              state_next = READY;
        end
        WAIT_ICW3: if (a0_reg) begin
          ld_icw3    = 1'b1;
          state_next = icw1[0] ? WAIT_ICW4 : READY;
        end
        WAIT_ICW4: if (a0_reg) begin
          ld_icw4    = 1'b1;
          state_next = READY;
        end
        READY: begin
          if (a0_reg)                     ld_imr  = 1'b1;
          else if (data_reg[4:3] == 2'b00) ld_ocw2 = 1'b1;
          else if (data_reg[4:3] == 2'b01) ld_ocw3 = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ICW/OCW registers, commit pulses and init_done tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icw1      <= REG_RST;
      icw2      <= REG_RST;
      icw3      <= REG_RST;
      icw4      <= REG_RST;
      imr       <= REG_RST;
      ocw2      <= REG_RST;
      ocw3      <= OCW3_RST;
      icw1_stb  <= 1'b0;
      ocw2_stb  <= 1'b0;
      ocw3_stb  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      icw1_stb <= is_icw1;
      ocw2_stb <= ld_ocw2;
      ocw3_stb <= ld_ocw3;
      if (is_icw1) begin
        icw1      <= data_reg;
        imr       <= REG_RST;
        icw4      <= REG_RST;
        ocw3      <= OCW3_RST;
        init_done <= 1'b0;
      end else begin
        if (ld_icw2) icw2 <= data_reg;
        if (ld_icw3) icw3 <= data_reg;
        if (ld_icw4) icw4 <= data_reg;
        if (ld_imr)  imr  <= data_reg;
        if (ld_ocw2) ocw2 <= data_reg;
        // RR/RIS bits only change when RR is set in the written word
        if (ld_ocw3) ocw3 <= {data_reg[7:2], data_reg[1] ? data_reg[1:0] : ocw3[1:0]};
        if (state_reg != READY && state_next == READY) init_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pic_read_write_logic.sv
// Scoreboard bench for pic_read_write_logic (default build, 1-clk sampling).
module tb_pic_read_write_logic;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_n, rd_n, wr_n, a0;
  logic [7:0] ds_in;
  logic       rd_flag, wr_flag;
  logic [1:0] read_sel;
  logic [7:0] icw1, icw2, icw3, icw4, imr, ocw2, ocw3;
  logic       icw1_stb, ocw2_stb, ocw3_stb, init_done;

  pic_read_write_logic dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0),
    .ds_in(ds_in), .rd_flag(rd_flag), .wr_flag(wr_flag), .read_sel(read_sel),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .imr(imr),
    .ocw2(ocw2), .ocw3(ocw3), .icw1_stb(icw1_stb), .ocw2_stb(ocw2_stb),
    .ocw3_stb(ocw3_stb), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Observed pulse-cycle counts (a 1-clk pulse adds exactly one)
  int n_icw1_seen = 0, n_ocw2_seen = 0, n_ocw3_seen = 0;
  always @(negedge clk) begin
    if (icw1_stb) n_icw1_seen++;
    if (ocw2_stb) n_ocw2_seen++;
    if (ocw3_stb) n_ocw3_seen++;
  end

  typedef struct {
    string      tag;
    logic [7:0] icw1, icw2, icw3, icw4, imr, ocw2, ocw3;
    logic       init_done;
    int         n_icw1, n_ocw2, n_ocw3;
  } snap_t;

  snap_t sb_q[$];

  // Reference model state (0 READY, 1 WAIT_ICW2, 2 WAIT_ICW3, 3 WAIT_ICW4)
  int         m_state;
  logic [7:0] m_icw1, m_icw2, m_icw3, m_icw4, m_imr, m_ocw2, m_ocw3;
  logic       m_init;
  int         m_n1 = 0, m_n2 = 0, m_n3 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_icw1 = 8'h00; m_icw2 = 8'h00; m_icw3 = 8'h00; m_icw4 = 8'h00;
    m_imr  = 8'h00; m_ocw2 = 8'h00; m_ocw3 = 8'h02; m_init = 1'b0;
  endtask

  task automatic model_write(input logic a, input logic [7:0] d);
    if (!a && d[4]) begin
      m_icw1 = d; m_imr = 8'h00; m_icw4 = 8'h00; m_ocw3 = 8'h02;
      m_init = 1'b0; m_n1++; m_state = 1;
    end else begin
      case (m_state)
        1: if (a) begin
          m_icw2 = d;
          if (!m_icw1[1]) m_state = 2;
          else if (m_icw1[0]) m_state = 3;
          else begin m_state = 0; m_init = 1'b1; end
        end
        2: if (a) begin
          m_icw3 = d;
          if (m_icw1[0]) m_state = 3;
          else begin m_state = 0; m_init = 1'b1; end
        end
        3: if (a) begin m_icw4 = d; m_state = 0; m_init = 1'b1; end
        default: begin
          if (a) m_imr = d;
          else if (d[4:3] == 2'b00) begin m_ocw2 = d; m_n2++; end
          else if (d[4:3] == 2'b01) begin
            m_n3++;
            m_ocw3 = {d[7:2], d[1] ? d[1:0] : m_ocw3[1:0]};
          end
        end
      endcase
    end
  endtask

  task automatic push_expected(input string tag);
    snap_t s;
    s.tag = tag;
    s.icw1 = m_icw1; s.icw2 = m_icw2; s.icw3 = m_icw3; s.icw4 = m_icw4;
    s.imr = m_imr; s.ocw2 = m_ocw2; s.ocw3 = m_ocw3; s.init_done = m_init;
    s.n_icw1 = m_n1; s.n_ocw2 = m_n2; s.n_ocw3 = m_n3;
    sb_q.push_back(s);
  endtask

  task automatic pop_compare();
    snap_t s;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    s = sb_q.pop_front();
    check({s.tag, ".icw1"}, icw1, s.icw1);
    check({s.tag, ".icw2"}, icw2, s.icw2);
    check({s.tag, ".icw3"}, icw3, s.icw3);
    check({s.tag, ".icw4"}, icw4, s.icw4);
    check({s.tag, ".imr"}, imr, s.imr);
    check({s.tag, ".ocw2"}, ocw2, s.ocw2);
    check({s.tag, ".ocw3"}, ocw3, s.ocw3);
    check({s.tag, ".init_done"}, init_done, s.init_done);
    check({s.tag, ".icw1_stb_cnt"}, n_icw1_seen, s.n_icw1);
    check({s.tag, ".ocw2_stb_cnt"}, n_ocw2_seen, s.n_ocw2);
    check({s.tag, ".ocw3_stb_cnt"}, n_ocw3_seen, s.n_ocw3);
  endtask

  // Clean write: WR# released before CS#; commit visible 2 clk after release
  task automatic do_write(input string tag, input logic a, input logic [7:0] d);
    $display("WR %s a0=%0d d=0x%02h", tag, a, d);
    @(negedge clk); cs_n = 1'b0; a0 = a; ds_in = d; wr_n = 1'b0;
    @(negedge clk); check({tag, ".wr_flag_hi"}, wr_flag, 1'b1);
    @(negedge clk); wr_n = 1'b1;
    model_write(a, d);
    push_expected(tag);
    @(negedge clk); check({tag, ".wr_flag_lo"}, wr_flag, 1'b0);
    @(negedge clk); #1;
    pop_compare();
    cs_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_read(input string tag, input logic a, input logic [1:0] exp_sel);
    $display("RD %s a0=%0d", tag, a);
    @(negedge clk); cs_n = 1'b0; a0 = a; rd_n = 1'b0;
    @(negedge clk);
    check({tag, ".rd_flag"}, rd_flag, 1'b1);
    check({tag, ".wr_flag"}, wr_flag, 1'b0);
    check({tag, ".read_sel"}, read_sel, exp_sel);
    rd_n = 1'b1; cs_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; ds_in = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    $display("CHK reset_state");
    check("rst.rd_flag", rd_flag, 1'b0);
    check("rst.wr_flag", wr_flag, 1'b0);
    check("rst.read_sel", read_sel, 2'b00);
    push_expected("rst");
    pop_compare();

    // Full init, cascade with ICW4
    do_write("init_icw1", 1'b0, 8'h11);
    do_write("init_icw2", 1'b1, 8'h40);
    do_write("init_icw3", 1'b1, 8'h04);
    do_write("init_icw4", 1'b1, 8'h01);

    // Single mode without ICW4
    do_write("single_icw1", 1'b0, 8'h12);
    do_write("single_icw2", 1'b1, 8'h08);

    // OCW traffic in READY
    do_write("ocw1", 1'b1, 8'hA5);
    do_write("ocw2", 1'b0, 8'h20);
    do_write("ocw3", 1'b0, 8'h0B);
    do_read("rd_isr", 1'b0, 2'b01);
    do_read("rd_imr", 1'b1, 2'b10);
    do_write("ocw3_keep_rr", 1'b0, 8'h08);
    do_read("rd_isr_kept", 1'b0, 2'b01);
    do_write("ocw3_irr", 1'b0, 8'h0A);
    do_read("rd_irr", 1'b0, 2'b00);

    // Restart from WAIT_ICW3; then single+IC4 proves WAIT_ICW2 was re-entered
    do_write("rs_icw1", 1'b0, 8'h11);
    do_write("rs_icw2", 1'b1, 8'h40);
    do_write("rs_restart", 1'b0, 8'h13);
    do_write("rs_wait_ignore", 1'b0, 8'h08);
    do_write("rs_icw2b", 1'b1, 8'h50);
    do_write("rs_icw4", 1'b1, 8'h02);

    // Illegal overlap: RD# and WR# low together, CS# raised first
    $display("WR overlap rd+wr");
    @(negedge clk); cs_n = 1'b0; a0 = 1'b1; ds_in = 8'hFF; rd_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    check("ovl.rd_flag", rd_flag, 1'b0);
    check("ovl.wr_flag", wr_flag, 1'b0);
    @(negedge clk); cs_n = 1'b1;
    @(negedge clk); rd_n = 1'b1; wr_n = 1'b1;
    repeat (2) @(negedge clk); #1;
    push_expected("ovl");
    pop_compare();

    // Aborted write: CS# deasserts while WR# still low
    $display("WR abort a0=1 d=0xff");
    @(negedge clk); cs_n = 1'b0; a0 = 1'b1; ds_in = 8'hFF; wr_n = 1'b0;
    @(negedge clk); check("abort.wr_flag_hi", wr_flag, 1'b1);
    cs_n = 1'b1;
    @(negedge clk); check("abort.wr_flag_lo", wr_flag, 1'b0);
    wr_n = 1'b1;
    repeat (2) @(negedge clk); #1;
    push_expected("abort");
    pop_compare();

    // Reset in WAIT_ICW4, checked before the next clock edge
    do_write("pr_icw1", 1'b0, 8'h11);
    do_write("pr_icw2", 1'b1, 8'h40);
    do_write("pr_icw3", 1'b1, 8'h04);
    $display("RST async during WAIT_ICW4");
    @(negedge clk); #2 rst_n = 1'b0; #1;
    model_reset();
    check("arst.rd_flag", rd_flag, 1'b0);
    check("arst.wr_flag", wr_flag, 1'b0);
    check("arst.read_sel", read_sel, 2'b00);
    check("arst.icw1_stb", icw1_stb, 1'b0);
    push_expected("arst");
    pop_compare();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    // After reset the FSM is READY with init_done low: a0=1 write is OCW1
    do_write("post_rst_ocw1", 1'b1, 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/pic_read_write_logic.md
# pic_read_write_logic

Read/write control logic of the 8259A-style PIC. Samples the CPU strobes (CS#, RD#, WR#, A0) and produces the RD/WR flags that steer the data bus buffer. It also consumes the byte the buffer forwards on a write, runs the ICW1–ICW4 initialization sequence, and holds the ICW/OCW registers used by the control, priority and mask logic.

## Interface
Parameters:
- None; data width is fixed at 8 per the 8259A.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cs_n  in  1  chip select, active low
- rd_n  in  1  CPU read strobe, active low
- wr_n  in  1  CPU write strobe, active low
- a0  in  1  register address bit
- ds_in  in  8  write byte from the data bus buffer
- rd_flag  out  1  read cycle active; drives the data bus buffer onto Ds
- wr_flag  out  1  write cycle active; buffer forwards Ds
- read_sel  out  2  read source: 00 IRR, 01 ISR, 10 IMR
- icw1, icw2, icw3, icw4  out  8 each  latched init words
- imr  out  8  OCW1 interrupt mask
- ocw2  out  8  last OCW2 written
- ocw3  out  8  last OCW3 written
- icw1_stb, ocw2_stb, ocw3_stb  out  1  one-cycle commit pulses
- init_done  out  1  initialization sequence complete

## Operation
Sampling:
- Strobes pass through the sampling stage (see Configuration).
- Sampled values: s_cs, s_rd, s_wr, s_a0.

Flags:
- rd_flag = s_cs & s_rd & !s_wr.
- wr_flag = s_cs & s_wr & !s_rd.
- If both strobes are low, both flags are 0 and no commit occurs.

Write capture and commit:
- While wr_flag = 1, ds_in and s_a0 are latched every cycle.
- A commit occurs on the first cycle where wr_flag falls from 1 to 0 and the cause is WR# deasserting. Commit uses the last latched data and address.
- If CS# deasserts first, the cycle is aborted with no commit.

Init FSM states: READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4.
- Commit with a0 = 0 and d[4] = 1 is ICW1, accepted from any state:
  - Latches icw1.
  - Clears imr and icw4 to 0x00.
  - Sets ocw3 to 0x02 (read IRR).
  - Pulses icw1_stb.
  - Clears init_done.
  - Goes to WAIT_ICW2.
- WAIT_ICW2, commit with a0 = 1: latch icw2, then
  - go to WAIT_ICW3 if icw1[1] = 0 (cascade);
  - else go to WAIT_ICW4 if icw1[0] = 1;
  - else go to READY.
- WAIT_ICW3, commit with a0 = 1: latch icw3, then go to WAIT_ICW4 if icw1[0] = 1, else READY.
- WAIT_ICW4, commit with a0 = 1: latch icw4, then go to READY.
- Entering READY sets init_done = 1.
- In any WAIT state, a commit with a0 = 0 and d[4] = 0 is ignored.
- READY decode:
  - a0 = 1: OCW1; imr ← d.
  - a0 = 0, d[4:3] = 00: OCW2; latch ocw2 and pulse ocw2_stb.
  - a0 = 0, d[4:3] = 01: OCW3; pulse ocw3_stb. Update ocw3[1:0] only when d[1] = 1. Other bits are always written.

read_sel:
- a0 = 1 selects IMR (10).
- Otherwise, ocw3[0] = 0 selects IRR (00) and ocw3[0] = 1 selects ISR (01).
- Valid whenever rd_flag = 1.

## Timing
- Reset values:
  - rd_flag, wr_flag and all strobe outputs: 0.
  - icw1–icw4, imr, ocw2: 0x00.
  - ocw3: 0x02.
  - read_sel: 00.
  - init_done: 0.
  - FSM state: READY with init_done = 0, until the first ICW1.
- Flag latency: with the macro defined, 2 clk from the pin edge to a flag change; without it, 1 clk.
- Commit latency: registers and the *_stb pulse update in the cycle after wr_flag falls.
- Each pulse is exactly 1 clk wide.
- Registers hold until the next commit or reset.
- Reset asserted mid-sequence: the FSM returns to its reset state immediately and any partially captured write is discarded.
- Back-to-back writes require WR# high for at least one sampled cycle between them.

## Configuration
- RW_SYNC_EN defined: each strobe and a0 passes through a 2-flop synchronizer, for asynchronous CPU pins.
- RW_SYNC_EN not defined: a single register stage, for pins already synchronous to clk.
- Logical behaviour is identical in both cases; only latency differs.

## Structure
- Shared package pic_pkg holds:
  - the init FSM state enum;
  - the read_sel encodings (SEL_IRR, SEL_ISR, SEL_IMR);
  - the reset constants OCW3_RST = 0x02 and REG_RST = 0x00.
- One sub-module, pic_strobe_sync: a per-bit synchronizer whose depth is selected by RW_SYNC_EN. It is instantiated once, 4 bits wide.

## Test plan
- Full init: ICW1 = 0x11 (cascade, IC4), ICW2 = 0x40, ICW3 = 0x04, ICW4 = 0x01.
  - Required: FSM steps through all states; icw1–icw4 match; init_done = 1 one clk after the ICW4 commit.
- Single mode without ICW4: ICW1 = 0x12, then ICW2 = 0x08.
  - Required: icw4 = 0x00; init_done rises after ICW2; WAIT_ICW3 and WAIT_ICW4 are skipped.
- In READY: write a0 = 1, 0xA5; then a0 = 0, 0x20; then a0 = 0, 0x0B.
  - Required: imr = 0xA5; ocw2 = 0x20 with ocw2_stb pulsing once; ocw3[1:0] = 11; read with a0 = 0 gives read_sel = 01.
- Restart: issue ICW1 = 0x13 while in WAIT_ICW3.
  - Required: back to WAIT_ICW2; imr = 0x00; ocw3 = 0x02; icw1_stb pulses.
- Illegal and aborted cycles: RD# and WR# low together, then CS# raised before WR#.
  - Required: rd_flag = wr_flag = 0 during the overlap; no register changes and no strobes.
- Reset: rst_n pulled low during WAIT_ICW4.
  - Required: all outputs return to reset values asynchronously; init_done = 0.
